// File: rtl/cache_line_mover_pkg.sv
// Shared definitions for the cache line mover: state encoding and line/beat geometry.
package cache_line_mover_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int LINE_SIZE_DEF = 64;
    localparam int BUS_WIDTH_DEF = 32;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_WAIT = 3'd2;
    localparam logic [2:0] ST_FILL    = 3'd3;
    localparam logic [2:0] ST_WR_REQ  = 3'd4;
    localparam logic [2:0] ST_WB_DONE = 3'd5;

    function automatic int calc_beats(input int line_size, input int bus_width);
        return (8 * line_size) / bus_width;
    endfunction

    localparam int BEATS      = calc_beats(LINE_SIZE_DEF, BUS_WIDTH_DEF);
    localparam int NOFFSET    = $clog2(LINE_SIZE_DEF);
    localparam int BEAT_BYTES = BUS_WIDTH_DEF / 8;

endpackage

// File: rtl/cache_line_mover_if.sv
// Cache-side request/fill port and memory beat bus of the line mover.
interface cache_line_mover_if #(
    parameter int XLEN      = 32,
    parameter int LINE_SIZE = 64,
    parameter int BUS_WIDTH = 32
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [XLEN-1:0]        req_addr;
    logic [8*LINE_SIZE-1:0] req_line;
    logic                   fill_write_en;
    logic [8*LINE_SIZE-1:0] fill_data;
    logic [XLEN-1:0]        fill_addr;
    logic                   done;
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic                   mem_req_write;
    logic [XLEN-1:0]        mem_req_addr;
    logic [BUS_WIDTH-1:0]   mem_req_wdata;
    logic                   mem_resp_valid;
    logic [BUS_WIDTH-1:0]   mem_resp_rdata;

    // master: the mover itself; slave: the cache plus memory around it
    modport master (
        input  req_valid, req_write, req_addr, req_line,
        output req_ready, fill_write_en, fill_data, fill_addr, done,
        output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_line,
        input  req_ready, fill_write_en, fill_data, fill_addr, done,
        input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata
    );
endinterface

// File: rtl/cache_line_mover.sv
// Moves whole cache lines between the cache fill port and a beat-wide memory bus,
// one outstanding beat at a time (refill: memory->cache, writeback: cache->memory).
module cache_line_mover
    import cache_line_mover_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int LINE_SIZE = 64,
    parameter int BUS_WIDTH = 32
) (
    input  logic clock,
    input  logic reset,
    cache_line_mover_if.master bus
);
    localparam int LINE_BITS      = 8 * LINE_SIZE;
    localparam int N_BEATS        = calc_beats(LINE_SIZE, BUS_WIDTH);
    localparam int OFF_BITS       = $clog2(LINE_SIZE);
    localparam int BYTES_PER_BEAT = BUS_WIDTH / 8;
    localparam int BEAT_W         = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

    logic [2:0]           state_reg, state_next;
    logic [BEAT_W-1:0]    beat_reg, beat_next;
    logic [XLEN-1:0]      base_reg, base_next;
    logic [LINE_BITS-1:0] line_reg, line_next;
    logic [LINE_BITS-1:0] fill_data_reg, fill_data_next;
    logic [XLEN-1:0]      fill_addr_reg, fill_addr_next;
    logic [BUS_WIDTH-1:0] beat_word [N_BEATS];

    generate
        for (genvar gi = 0; gi < N_BEATS; gi++) begin : g_beat
            assign beat_word[gi] = line_reg[gi*BUS_WIDTH +: BUS_WIDTH];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        beat_next      = beat_reg;
        base_next      = base_reg;
        line_next      = line_reg;
        fill_data_next = fill_data_reg;
        fill_addr_next = fill_addr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    base_next = {bus.req_addr[XLEN-1:OFF_BITS], {OFF_BITS{1'b0}}};
                    beat_next = '0;
                    if (bus.req_write) begin
                        line_next  = bus.req_line;
                        state_next = ST_WR_REQ;
                    end else begin
                        state_next = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                if (bus.mem_req_ready) state_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (bus.mem_resp_valid) begin
                    line_next[int'(beat_reg)*BUS_WIDTH +: BUS_WIDTH] = bus.mem_resp_rdata;
                    if (beat_reg == LAST_BEAT) begin
                        // Latch the output copy now so it holds through later writebacks.
                        fill_data_next = line_next;
                        fill_addr_next = base_reg;
                        state_next     = ST_FILL;
                    end else begin
                        beat_next  = beat_reg + 1'b1;
                        state_next = ST_RD_REQ;
                    end
                end
            end
            ST_FILL: state_next = ST_IDLE;
            ST_WR_REQ: begin
                if (bus.mem_req_ready) begin
                    if (beat_reg == LAST_BEAT) state_next = ST_WB_DONE;
                    else                       beat_next  = beat_reg + 1'b1;
                end
            end
            ST_WB_DONE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            beat_reg      <= '0;
            base_reg      <= '0;
            line_reg      <= '0;
            fill_data_reg <= '0;
            fill_addr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            beat_reg      <= beat_next;
            base_reg      <= base_next;
            line_reg      <= line_next;
            fill_data_reg <= fill_data_next;
            fill_addr_reg <= fill_addr_next;
        end
    end

    // Bus fields derive only from registered state, so they hold while ready is low.
    assign bus.req_ready     = (state_reg == ST_IDLE);
    assign bus.mem_req_valid = (state_reg == ST_RD_REQ) || (state_reg == ST_WR_REQ);
    assign bus.mem_req_write = (state_reg == ST_WR_REQ);
    assign bus.mem_req_addr  = base_reg + XLEN'(int'(beat_reg) * BYTES_PER_BEAT);
    assign bus.mem_req_wdata = beat_word[beat_reg];
    assign bus.fill_write_en = (state_reg == ST_FILL);
    assign bus.done          = (state_reg == ST_FILL) || (state_reg == ST_WB_DONE);
    assign bus.fill_data     = fill_data_reg;
    assign bus.fill_addr     = fill_addr_reg;

endmodule

// File: tb/tb_cache_line_mover.sv
// Directed bench for cache_line_mover with a one-beat-latency memory model.
module tb_cache_line_mover;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    cache_line_mover_if #(.XLEN(32), .LINE_SIZE(64), .BUS_WIDTH(32)) bus();
    cache_line_mover #(.XLEN(32), .LINE_SIZE(64), .BUS_WIDTH(32)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // memory model state
    bit          pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] rd_key = '0;
    int          stall_left = 0;
    logic [31:0] stall_addr = '0;
    bit          stalled_prev = 1'b0;
    logic [31:0] hold_addr = '0;
    logic [31:0] hold_wdata = '0;
    logic        hold_write = 1'b0;
    bit          spur_idle = 1'b0;
    bit          spur_en = 1'b0;
    logic [31:0] spur_addr = '0;
    logic [31:0] rd_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    always @(negedge clock) begin
        bus.mem_resp_valid = pend;
        bus.mem_resp_rdata = pend_addr ^ rd_key;
        pend = 1'b0;
        if (spur_idle && bus.req_ready) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_rdata = 32'hDEAD_BEEF;
            spur_idle = 1'b0;
        end
        if (spur_en && bus.mem_req_valid && !bus.mem_req_write && bus.mem_req_addr == spur_addr) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_rdata = 32'hBAD0_0BAD;
            spur_en = 1'b0;
        end
        if (stalled_prev) begin
            check("stall_addr_hold", bus.mem_req_addr, hold_addr);
            check("stall_wdata_hold", bus.mem_req_wdata, hold_wdata);
            check("stall_write_hold", bus.mem_req_write, hold_write);
        end
        bus.mem_req_ready = 1'b1;
        if (stall_left > 0 && bus.mem_req_valid && bus.mem_req_addr == stall_addr) begin
            bus.mem_req_ready = 1'b0;
            stall_left--;
        end
        stalled_prev = bus.mem_req_valid && !bus.mem_req_ready;
        hold_addr  = bus.mem_req_addr;
        hold_wdata = bus.mem_req_wdata;
        hold_write = bus.mem_req_write;
        if (bus.mem_req_valid && bus.mem_req_ready) begin
            if (bus.mem_req_write) begin
                wr_addr_q.push_back(bus.mem_req_addr);
                wr_data_q.push_back(bus.mem_req_wdata);
            end else begin
                rd_q.push_back(bus.mem_req_addr);
                pend = 1'b1;
                pend_addr = bus.mem_req_addr;
            end
        end
    end

    function automatic logic [511:0] rd_line(input logic [31:0] base, input logic [31:0] key);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = (base + 32'(4*i)) ^ key;
        return l;
    endfunction

    function automatic logic [511:0] seq_line(input logic [31:0] seed);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = seed + 32'(i);
        return l;
    endfunction

    task automatic clear_logs();
        rd_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [511:0] line, input bit hold);
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_line  = line;
        check("req_ready_idle", bus.req_ready, 1'b1);
        @(posedge clock);
        #1;
        if (!hold) begin
            bus.req_valid = 1'b0;
            bus.req_line  = ~line;
        end
    endtask

    // lat counts cycles with the handshake cycle as cycle 1; 0 means no done seen.
    task automatic run_xfer(input int max_cycles, output int lat, output int fills, output int busy_ready);
        lat = 0; fills = 0; busy_ready = 0;
        for (int n = 1; n <= max_cycles; n++) begin
            @(posedge clock);
            #1;
            if (bus.fill_write_en) fills++;
            if (bus.done) begin
                lat = n + 1;
                break;
            end
            if (bus.req_ready) busy_ready++;
        end
        @(posedge clock);
        #1;
        check("done_single_pulse", bus.done, 1'b0);
        check("fill_single_pulse", bus.fill_write_en, 1'b0);
    endtask

    task automatic check_reads(input string tag, input logic [31:0] base);
        check({tag, "_rd_count"}, 32'(rd_q.size()), 32'd16);
        for (int i = 0; i < 16; i++)
            check($sformatf("%s_rd_addr%0d", tag, i), (i < rd_q.size()) ? rd_q[i] : 32'hx, base + 32'(4*i));
    endtask

    task automatic check_writes(input string tag, input logic [31:0] base, input logic [31:0] seed);
        check({tag, "_wr_count"}, 32'(wr_addr_q.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_wr_addr%0d", tag, i), (i < wr_addr_q.size()) ? wr_addr_q[i] : 32'hx, base + 32'(4*i));
            check($sformatf("%s_wr_data%0d", tag, i), (i < wr_data_q.size()) ? wr_data_q[i] : 32'hx, seed + 32'(i));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"}, bus.req_ready, 1'b1);
        check({tag, "_mem_req_valid"}, bus.mem_req_valid, 1'b0);
        check({tag, "_fill_write_en"}, bus.fill_write_en, 1'b0);
        check({tag, "_done"}, bus.done, 1'b0);
        check({tag, "_mem_req_addr"}, bus.mem_req_addr, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, fills, busy_ready, events;
        bit found;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_line  = '0;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = '0;

        // reset state, then an asynchronous pulse mid-idle
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check_idle_outputs("rst");
        check("rst_fill_data", bus.fill_data, 512'h0);
        check("rst_fill_addr", bus.fill_addr, 32'h0);
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check_idle_outputs("rst_pulse");
        #3 reset = 1'b0;

        // plain refill
        clear_logs();
        issue(1'b0, 32'h0000_1234, 512'h0, 1'b0);
        run_xfer(60, lat, fills, busy_ready);
        $display("refill 0x00001234: latency=%0d fills=%0d", lat, fills);
        check("refill_latency", 32'(lat), 32'd33);
        check("refill_fill_count", 32'(fills), 32'd1);
        check("refill_busy_ready", 32'(busy_ready), 32'd0);
        check("refill_fill_addr", bus.fill_addr, 32'h0000_1200);
        check("refill_fill_data", bus.fill_data, rd_line(32'h0000_1200, 32'h0));
        check_reads("refill", 32'h0000_1200);

        // plain writeback; fill outputs must keep the previous refill
        clear_logs();
        issue(1'b1, 32'h8000_0047, seq_line(32'hA0), 1'b0);
        run_xfer(60, lat, fills, busy_ready);
        $display("writeback 0x80000047: latency=%0d fills=%0d", lat, fills);
        check("wb_latency", 32'(lat), 32'd17);
        check("wb_fill_count", 32'(fills), 32'd0);
        check("wb_rd_count", 32'(rd_q.size()), 32'd0);
        check_writes("wb", 32'h8000_0040, 32'hA0);
        check("wb_fill_addr_hold", bus.fill_addr, 32'h0000_1200);
        check("wb_fill_data_hold", bus.fill_data, rd_line(32'h0000_1200, 32'h0));

        // refill with 3 stalled cycles at beat 5
        clear_logs();
        rd_key = 32'h5A5A_0000;
        stall_addr = 32'h0000_2014;
        stall_left = 3;
        issue(1'b0, 32'h0000_2000, 512'h0, 1'b0);
        run_xfer(60, lat, fills, busy_ready);
        $display("refill 0x00002000 stalled: latency=%0d", lat);
        check("bp_refill_latency", 32'(lat), 32'd36);
        check("bp_refill_stall_used", 32'(stall_left), 32'd0);
        check("bp_refill_fill_data", bus.fill_data, rd_line(32'h0000_2000, 32'h5A5A_0000));
        check_reads("bp_refill", 32'h0000_2000);

        // writeback with 3 stalled cycles at beat 5
        clear_logs();
        stall_addr = 32'h4000_0114;
        stall_left = 3;
        issue(1'b1, 32'h4000_0100, seq_line(32'h1111_0000), 1'b0);
        run_xfer(60, lat, fills, busy_ready);
        $display("writeback 0x40000100 stalled: latency=%0d", lat);
        check("bp_wb_latency", 32'(lat), 32'd20);
        check("bp_wb_stall_used", 32'(stall_left), 32'd0);
        check_writes("bp_wb", 32'h4000_0100, 32'h1111_0000);

        // spurious response in IDLE, then one in RD_REQ of the next refill
        spur_idle = 1'b1;
        events = 0;
        repeat (3) begin
            @(posedge clock);
            #1;
            if (bus.done || bus.fill_write_en || bus.mem_req_valid) events++;
        end
        $display("spurious idle response: events=%0d", events);
        check("spur_idle_used", spur_idle, 1'b0);
        check("spur_idle_events", 32'(events), 32'd0);
        check("spur_idle_fill_hold", bus.fill_data, rd_line(32'h0000_2000, 32'h5A5A_0000));
        clear_logs();
        rd_key = 32'h0;
        spur_addr = 32'h0000_330C;
        spur_en = 1'b1;
        issue(1'b0, 32'h0000_3330, 512'h0, 1'b0);
        run_xfer(60, lat, fills, busy_ready);
        $display("refill 0x00003330 with spurious response: latency=%0d", lat);
        check("spur_rdreq_used", spur_en, 1'b0);
        check("spur_refill_latency", 32'(lat), 32'd33);
        check("spur_refill_fill_data", bus.fill_data, rd_line(32'h0000_3300, 32'h0));
        check("spur_refill_rd_count", 32'(rd_q.size()), 32'd16);

        // req_valid held through a writeback: next accept is the cycle after done
        clear_logs();
        issue(1'b1, 32'h0000_5000, seq_line(32'hC0), 1'b1);
        run_xfer(60, lat, fills, busy_ready);
        $display("held-request writeback: latency=%0d busy_ready=%0d", lat, busy_ready);
        check("hold_latency", 32'(lat), 32'd17);
        check("hold_busy_ready", 32'(busy_ready), 32'd0);
        check("hold_idle_after_done", bus.req_ready, 1'b1);
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        check("hold_reaccept_ready", bus.req_ready, 1'b0);
        check("hold_reaccept_addr", bus.mem_req_addr, 32'h0000_5000);
        run_xfer(60, lat, fills, busy_ready);
        check("hold_second_latency", 32'(lat), 32'd17);
        check("hold_total_writes", 32'(wr_addr_q.size()), 32'd32);

        // reset during beat 7 of a refill
        clear_logs();
        issue(1'b0, 32'h0000_7000, 512'h0, 1'b0);
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(posedge clock);
            #1;
            if (bus.mem_req_valid && bus.mem_req_addr == 32'h0000_701C) found = 1'b1;
        end
        check("abort_reached_beat7", found, 1'b1);
        reset = 1'b1;
        #1;
        $display("reset asserted mid-refill at beat 7");
        check_idle_outputs("abort");
        @(negedge clock);
        reset = 1'b0;
        events = 0;
        repeat (5) begin
            @(posedge clock);
            #1;
            if (bus.done || bus.fill_write_en || bus.mem_req_valid) events++;
        end
        check("abort_quiet", 32'(events), 32'd0);
        check("abort_reads", 32'(rd_q.size()), 32'd7);
        clear_logs();
        issue(1'b0, 32'h0000_7010, 512'h0, 1'b0);
        run_xfer(60, lat, fills, busy_ready);
        $display("refill 0x00007010 after abort: latency=%0d", lat);
        check("restart_latency", 32'(lat), 32'd33);
        check("restart_fill_addr", bus.fill_addr, 32'h0000_7000);
        check("restart_fill_data", bus.fill_data, rd_line(32'h0000_7000, 32'h0));
        check_reads("restart", 32'h0000_7000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cache_line_mover.md
Name: cache_line_mover

Overview:
Memory-side partner of the set-associative cache. On a refill request it fetches one cache line from memory as BUS_WIDTH-bit beats over a valid/ready bus, assembles the beats into a full line, and presents it to the cache with a one-cycle fill write strobe. On a writeback request it takes a victim line and sends it to memory as sequential beat writes. It sits between the cache's line-fill port and the memory bus.

Parameters:
XLEN, 32, address width
LINE_SIZE, 64, line size in bytes; power of two
BUS_WIDTH, 32, memory data beat width in bits; must divide 8*LINE_SIZE

Ports:
clock  in  1  single clock, rising-edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  transfer request
req_ready  out  1  high only in IDLE; handshake when req_valid&&req_ready
req_write  in  1  0=refill (memory->cache), 1=writeback (cache->memory)
req_addr  in  XLEN  any byte address inside the target line
req_line  in  8*LINE_SIZE  victim line for writeback; sampled at handshake
fill_write_en  out  1  one-cycle strobe to the cache's memory-write enable
fill_data  out  8*LINE_SIZE  assembled line to the cache's data input
fill_addr  out  XLEN  line-aligned address of the filled line
done  out  1  one-cycle pulse when a transfer completes
mem_req_valid  out  1  memory beat request
mem_req_ready  in  1  memory accepts the beat
mem_req_write  out  1  beat is a write
mem_req_addr  out  XLEN  beat byte address
mem_req_wdata  out  BUS_WIDTH  write beat data
mem_resp_valid  in  1  read data valid
mem_resp_rdata  in  BUS_WIDTH  read data

Behaviour:
- Derived constants: BEATS=8*LINE_SIZE/BUS_WIDTH, NOFFSET=log2(LINE_SIZE), BEAT_BYTES=BUS_WIDTH/8.
- Reset (async, immediate): state IDLE, beat counter 0, line buffer 0, fill_write_en=0, done=0, mem_req_valid=0, mem_req_write=0, mem_req_addr=0, mem_req_wdata=0, fill_addr=0, fill_data=0. req_ready=1.
- At handshake: capture base = req_addr with low NOFFSET bits cleared. Capture req_write. Capture req_line into the line buffer when req_write=1. Clear the beat counter.
- States and transitions:
  - IDLE -> RD_REQ on handshake with req_write=0; IDLE -> WR_REQ on handshake with req_write=1.
  - RD_REQ: mem_req_valid=1, mem_req_write=0, mem_req_addr=base+beat*BEAT_BYTES. On mem_req_ready -> RD_WAIT.
  - RD_WAIT: mem_req_valid=0. On mem_resp_valid, store rdata into buffer[beat*BUS_WIDTH +: BUS_WIDTH]. If beat==BEATS-1 -> FILL; otherwise increment beat and go to RD_REQ.
  - FILL (1 cycle): fill_write_en=1, done=1, fill_addr=base, fill_data=buffer -> IDLE.
  - WR_REQ: mem_req_valid=1, mem_req_write=1, mem_req_addr as above, mem_req_wdata=buffer[beat*BUS_WIDTH +: BUS_WIDTH]. On mem_req_ready: if last beat -> WB_DONE, otherwise increment beat. There is no write response.
  - WB_DONE (1 cycle): done=1, fill_write_en=0 -> IDLE.
- Only one beat is outstanding at a time. Beat 0 is the lowest address and occupies the least-significant bits of the line.
- While mem_req_valid=1 and mem_req_ready=0, the bus address, data and write fields hold stable.
- mem_resp_valid outside RD_WAIT is ignored, including a response in the same cycle as the request handshake.
- req_valid while busy is not accepted because req_ready=0. Requests are never queued.
- fill_data and fill_addr hold their values after FILL until the next FILL.
- Reset mid-transfer aborts at once: no fill_write_en, no done, and no further bus beats.
- Latency with mem_req_ready=1 and response one cycle after the request: refill = 2*BEATS+1 cycles from handshake to fill_write_en (33 at defaults); writeback = BEATS+1 cycles to done (17).

Decomposition:
- Shared cache header/package: state encoding (IDLE, RD_REQ, RD_WAIT, FILL, WR_REQ, WB_DONE) and the derived constants BEATS, NOFFSET, BEAT_BYTES, shared with the cache.
- The datapath is a single module: one line buffer with indexed beat write and beat read. No sub-module is required.

Test Plan:
- Reset: after reset deasserts, req_ready=1, mem_req_valid=0, fill_write_en=0, done=0. Pulse reset again mid-idle: all outputs remain at reset values.
- Refill req_addr=0x0000_1234, memory returns rdata=beat address one cycle after each request: beat addresses 0x1200..0x123C in steps of 4, fill_data word i=0x1200+4i, fill_addr=0x1200, single fill_write_en and done pulse 33 cycles after handshake.
- Writeback req_addr=0x8000_0047 with line word i=0xA0+i: 16 writes to 0x8000_0040+4i with wdata 0xA0+i, done pulse at cycle 17, fill_write_en never asserted.
- Backpressure: hold mem_req_ready=0 for 3 cycles at beat 5 of both refill and writeback: addr/wdata stable throughout, no beat skipped or duplicated, completion delayed exactly 3 cycles.
- Spurious and overlapping inputs: mem_resp_valid pulses in IDLE and RD_REQ are ignored (buffer unchanged); req_valid held during a transfer is accepted only the cycle after done.
- Reset asserted during beat 7 of a refill: state IDLE in the same cycle, no fill_write_en/done; a following refill restarts at beat 0 with a correct line.
